// File: rtl/count_ctrl_pkg.sv
// Shared types and default sizing for the counter enable controller.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } ctrl_state_t;

    localparam int DEF_DB_CYCLES  = 16;
    localparam int DEF_PRESCALE_W = 8;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces the raw push-button and emits a one-cycle
// pulse on each accepted press.
module btn_debounce
    import count_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press
);

    localparam int              CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          vld1;
    logic          vld2;
    logic          armed;
    logic [CW-1:0] cnt;

    // A button held through reset must not count as a fresh press, so
    // presses are only honoured once a real low sample has been seen.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the synchronizer chain
    // depends on this).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            vld1      <= 1'b0;
            vld2      <= 1'b0;
            armed     <= 1'b0;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            sync1     <= btn_in;
            sync2     <= sync1;
            vld1      <= 1'b1;
            vld2      <= vld1;
            btn_press <= 1'b0;
            if (vld2 && !sync2)
                armed <= 1'b1;
            if (sync2 == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_level <= sync2;
                cnt       <= '0;
                btn_press <= sync2 & armed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_enable_ctrl.sv
// Run/stop/single-step controller producing the one-cycle enable tick
// for the downstream 4-bit counter.
module count_enable_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_in,
    input  logic                  step_req,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  en,
    output logic                  running,
    output logic                  btn_press
);

    ctrl_state_t           state;
    ctrl_state_t           state_nxt;
    logic [PRESCALE_W-1:0] pcnt;
    logic [PRESCALE_W-1:0] pcnt_nxt;
    logic                  en_nxt;
    logic                  step_d;
    logic                  step_rise;
    logic                  btn_level;
    logic                  press_evt;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_press (btn_press)
    );

    // A press pulse always coincides with the level going high.
    assign press_evt = btn_press & btn_level;
    assign step_rise = step_req & ~step_d;

    // NOTE: every output of this block gets a default first, so no
    // path leaves a value held and no latch is inferred.
    always_comb begin
        state_nxt = state;
        pcnt_nxt  = '0;
        en_nxt    = 1'b0;
        unique case (state)
            STOP: begin
                if (press_evt) begin
                    state_nxt = RUN;
                end else if (step_rise) begin
                    state_nxt = STEP;
                    en_nxt    = 1'b1;
                end
            end
            RUN: begin
                if (press_evt)
                    state_nxt = STOP;
                else if (pcnt >= prescale)
                    en_nxt = 1'b1;
                else
                    pcnt_nxt = pcnt + 1'b1;
            end
            STEP:    state_nxt = STOP;
            default: state_nxt = STOP;
        endcase
    end

    // Outputs are registered alongside the state so en is high exactly
    // during STEP and on the RUN tick cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= STOP;
            pcnt    <= '0;
            en      <= 1'b0;
            running <= 1'b0;
            step_d  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pcnt    <= pcnt_nxt;
            en      <= en_nxt;
            running <= (state_nxt == RUN);
            step_d  <= step_req;
        end
    end

endmodule

// File: doc/count_enable_ctrl.md
COUNT_ENABLE_CTRL -- requirements
Module: count_enable_ctrl
Upstream stage: turns a raw push-button and a step request into the one-cycle en tick that drives the 4-bit counter.

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16: consecutive synchronized samples needed to accept a new button level; legal range >= 2.
REQ-002 SHALL have parameter PRESCALE_W, default 8: width of the prescale input and of the internal prescale counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port btn_in, input, 1: raw button, asynchronous to clk, may bounce.
REQ-006 SHALL have port step_req, input, 1: synchronous single-step request; only its rising edge acts.
REQ-007 SHALL have port prescale, input, PRESCALE_W: tick period minus 1 while running.
REQ-008 SHALL have port en, output, 1: registered one-cycle enable tick to the counter.
REQ-009 SHALL have port running, output, 1: registered, high while the FSM is in RUN.
REQ-010 SHALL have port btn_press, output, 1: registered one-cycle pulse on each debounced press.

Function
REQ-011 SHALL pass btn_in through a 2-flop synchronizer before any use.
REQ-012 SHALL keep a debounced level plus a counter; counter resets to 0 on any synchronized sample equal to the level, else increments; on the DB_CYCLES-th consecutive differing sample, level flips and counter resets to 0.
REQ-013 SHALL pulse btn_press for exactly one cycle per debounced 0->1 transition, no earlier than DB_CYCLES+1 and no later than DB_CYCLES+3 cycles after btn_in rises and stays high; a release produces no pulse.
REQ-014 SHALL ignore any btn_in pulse shorter than DB_CYCLES-1 cycles.
REQ-015 SHALL implement FSM states STOP, RUN, STEP; reset state STOP.
REQ-016 STOP: btn_press -> RUN; step_req rising edge -> STEP; both in the same cycle -> RUN only.
REQ-017 RUN: btn_press -> STOP; step_req edges ignored.
REQ-018 STEP: en=1 for that one cycle, then unconditionally -> STOP.
REQ-019 SHALL clear the prescale counter on entering RUN and in every non-RUN cycle.
REQ-020 In RUN, en SHALL assert for one cycle when prescale counter >= prescale, with the counter then returning to 0; otherwise the counter increments and en=0.
REQ-021 Tick period in RUN SHALL be prescale+1 cycles; the first en comes prescale+1 cycles after running rises; prescale=0 gives en every RUN cycle.
REQ-022 A prescale decrease below the current count SHALL give a tick on the next cycle; there is no counter wrap-around.
REQ-023 en SHALL be 0 in STOP and in the cycle RUN->STOP is taken.

Reset
REQ-024 With rst high at a clock edge: en=0, running=0, btn_press=0, FSM=STOP, and all counters, synchronizer flops, debounced level and step_req edge-detect register cleared to 0.
REQ-025 rst mid-RUN or mid-debounce SHALL take effect at the next edge with no residual tick; a button still held after rst is released SHALL NOT produce btn_press until it is released and pressed again, since the level re-qualifies from 0.

Structure
REQ-026 Package count_ctrl_pkg SHALL hold the FSM state enum (STOP, RUN, STEP) and the default DB_CYCLES/PRESCALE_W constants.
REQ-027 The synchronizer, debounce and press detect SHALL live in sub-module btn_debounce (clk, rst, btn_in -> btn_level, btn_press); the FSM and prescaler are in the top.

Verification (DB_CYCLES=4, prescale=3 unless stated)
REQ-028 rst high 3 cycles with btn_in=1, step_req=1 -> en=0, running=0, btn_press=0 throughout and in the first cycle after release.
REQ-029 btn_in high 2 cycles then low -> no btn_press, running stays 0; bounce 1/0/1/0 then held 10 cycles -> exactly one btn_press in cycles 5-7.
REQ-030 Clean press in STOP -> running=1; en at 4, 8, 12 cycles after running rises; second press -> running=0, en stays 0.
REQ-031 step_req held high 3 cycles in STOP -> exactly one en pulse, running stays 0; step_req edge in RUN -> no extra en.
REQ-032 prescale=0 in RUN -> en every cycle; change prescale 7->2 when count=5 -> en next cycle, then every 3 cycles.
REQ-033 rst asserted mid-RUN with btn_in held -> en=0 and running=0 at the next edge; no btn_press until btn_in is released and pressed again.
